common_ram_arb2: RTL and testbench
==================================

// Module: common_ram_arb2
// PURPOSE
//  Two-requester arbiter for one single-port RAM macro in the fpga_ram sim models. It owns the 2:1 select
//  (SEL) that steers requester 0/1 address/write data onto the shared port. Per-cycle handshake, round-robin
//  fairness, bounded burst locking, and routing of read data back to the issuing requester after RD_LAT cycles.
// PARAMETERS
//  AW       10  address width
//  DW       40  data width
//  RD_LAT   1   RAM read latency in cycles, >=1 (RAM_RD valid RD_LAT cycles after RAM_EN & !RAM_WE)
//  MAX_LOCK 8   max consecutive accesses by a locked owner while the other port is requesting, >=1
// PORTS
//  CLK       in   1   clock, all state on rising edge
//  RST       in   1   synchronous reset, active high
//  REQ0/REQ1 in   1   access request; held until ACKx
//  WE0/WE1   in   1   1 = write, 0 = read; qualified by REQx
//  ADDR0/1   in   AW  address
//  WD0/WD1   in   DW  write data
//  LOCK0/1   in   1   keep ownership after this access (burst)
//  ACK0/ACK1 out  1   access accepted this cycle (combinational)
//  RVALID0/1 out  1   read data valid for port x, 1-cycle pulse
//  RD0/RD1   out  DW  read data (= RAM_RD, qualify with RVALIDx)
//  SEL       out  1   mux select: port granted this cycle; holds last grant when idle
//  RAM_EN    out  1   RAM access strobe
//  RAM_WE    out  1   RAM write enable
//  RAM_ADDR  out  AW  RAM address (SEL ? ADDR1 : ADDR0)
//  RAM_WD    out  DW  RAM write data (SEL ? WD1 : WD0)
//  RAM_RD    in   DW  RAM read data
// BEHAVIOUR
//  - Registers: state {IDLE, OWN0, OWN1}, PRI (preferred port), lock_cnt (clog2(MAX_LOCK+1) bits),
//    SEL register, read pipe of RD_LAT stages {v, id}.
//  - Reset: state=IDLE, PRI=0, lock_cnt=0, SEL=0, pipe cleared. While RST=1: ACKx=0, RAM_EN=0, RAM_WE=0,
//    RVALIDx=0. Reset mid-burst or with reads in flight drops them; no RVALID after RST.
//  - Grant g (combinational, at most one port per cycle):
//    IDLE: both REQ -> g=PRI; single REQ -> that port; none -> no grant.
//    OWNx: REQx & (lock_cnt<MAX_LOCK | !REQy) -> g=x; else REQy -> g=y; else no grant.
//  - On grant: ACKg=1, RAM_EN=1, RAM_WE=WEg, RAM_ADDR/RAM_WD from port g (SEL output = g same cycle).
//  - Update on granted cycle: PRI<=~g; SEL reg<=g; if LOCKg: state<=OWNg, lock_cnt<=(state==OWNg)?
//    sat(lock_cnt+1):1; else state<=IDLE, lock_cnt<=0.
//  - No grant: state<=IDLE, lock_cnt<=0, PRI and SEL hold. Owner dropping REQ releases lock.
//  - Forced switch: owner at lock_cnt==MAX_LOCK with other requesting loses that cycle; ownership
//    passes only if the new grantee has LOCK set.
//  - Read return: granted read enters pipe stage 1 {1,g}; RVALIDg=1 exactly RD_LAT cycles after ACKg,
//    pipelined, one per cycle, issue order preserved. Writes produce no RVALID.
//  - Throughput: one access per cycle; back-to-back reads from alternating ports fully pipelined.
// TESTING
//  1 Reset: RST=1 2 cycles with REQ0=REQ1=1 -> ACK0/1=0, RAM_EN=0, SEL=0; first cycle after -> ACK0=1.
//  2 Round robin: REQ0=REQ1=1, LOCK=0, 6 cycles -> grants 0,1,0,1,0,1; SEL follows; PRI=0 at end.
//  3 Reads, RD_LAT=2: read p0 @A=5 cycle t, read p1 @A=9 t+1 -> RVALID0 at t+2, RVALID1 at t+3, RD matches.
//  4 Lock cap, MAX_LOCK=8: REQ0+LOCK0 held, REQ1 from cycle 3 -> port0 granted 8 in a row, then ACK1.
//  5 Lock release: OWN0, REQ0 dropped 1 cycle, REQ1=1 -> ACK1 that cycle, state IDLE/OWN1 per LOCK1.
//  6 Reset mid-flight: read accepted, RST at next cycle -> no RVALID, pipe empty, SEL=0.

Source files
------------

// File: rtl/common_ram_arb2.sv
// Two-requester arbiter for a single-port RAM: round-robin grant with bounded
// burst locking, shared-port steering, and read-data return to the issuing port.
module common_ram_arb2 #(
  parameter int unsigned AW       = 10,
  parameter int unsigned DW       = 40,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req0_i,
  input  logic          req1_i,
  input  logic          we0_i,
  input  logic          we1_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [AW-1:0] addr1_i,
  input  logic [DW-1:0] wd0_i,
  input  logic [DW-1:0] wd1_i,
  input  logic          lock0_i,
  input  logic          lock1_i,
  output logic          ack0_o,
  output logic          ack1_o,
  output logic          rvalid0_o,
  output logic          rvalid1_o,
  output logic [DW-1:0] rd0_o,
  output logic [DW-1:0] rd1_o,
  output logic          sel_o,
  output logic          ram_en_o,
  output logic          ram_we_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_wd_o,
  input  logic [DW-1:0] ram_rd_i
);

  localparam int unsigned LCW = $clog2(MAX_LOCK + 1);
  localparam logic [LCW-1:0] LOCK_MAX = LCW'(MAX_LOCK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              pri_q, pri_d;
  logic              sel_q, sel_d;
  logic [LCW-1:0]    lock_cnt_q, lock_cnt_d;
  logic [RD_LAT-1:0] pv_q, pv_d;
  logic [RD_LAT-1:0] pid_q, pid_d;

  logic gnt_v;
  logic gnt_id;
  logic cap_ok;
  logic we_g;
  logic lock_g;

  assign cap_ok = (lock_cnt_q < LOCK_MAX);
  assign we_g   = gnt_id ? we1_i : we0_i;
  assign lock_g = gnt_id ? lock1_i : lock0_i;

  // Grant decision: owner keeps the port until its cap is hit with the other side waiting
  always_comb begin
    gnt_v  = 1'b0;
    gnt_id = 1'b0;
    case (state_q)
      OWN0: begin
        if (req0_i && (cap_ok || !req1_i)) begin
          gnt_v  = 1'b1;
          gnt_id = 1'b0;
        end else if (req1_i) begin
          gnt_v  = 1'b1;
          gnt_id = 1'b1;
        end
      end
      OWN1: begin
        if (req1_i && (cap_ok || !req0_i)) begin
          gnt_v  = 1'b1;
          gnt_id = 1'b1;
        end else if (req0_i) begin
          gnt_v  = 1'b1;
          gnt_id = 1'b0;
        end
      end
      default: begin
        if (req0_i && req1_i) begin
          gnt_v  = 1'b1;
          gnt_id = pri_q;
        end else if (req0_i) begin
          gnt_v  = 1'b1;
          gnt_id = 1'b0;
        end else if (req1_i) begin
          gnt_v  = 1'b1;
          gnt_id = 1'b1;
        end
      end
    endcase
    if (rst_i) begin
      gnt_v = 1'b0;
    end
  end

  // Next-state: ownership, fairness pointer, lock counter and read-return pipe
  always_comb begin
    state_d    = IDLE;
    lock_cnt_d = '0;
    pri_d      = pri_q;
    sel_d      = sel_q;
    if (gnt_v) begin
      pri_d = ~gnt_id;
      sel_d = gnt_id;
      if (lock_g) begin
        state_d = gnt_id ? OWN1 : OWN0;
        if (state_q == state_d) begin
          lock_cnt_d = (lock_cnt_q == LOCK_MAX) ? lock_cnt_q : lock_cnt_q + LCW'(1);
        end else begin
          lock_cnt_d = LCW'(1);
        end
      end
    end
    pv_d  = RD_LAT'({pv_q, (gnt_v & ~we_g)});
    pid_d = RD_LAT'({pid_q, gnt_id});
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      pri_q      <= 1'b0;
      sel_q      <= 1'b0;
      lock_cnt_q <= '0;
      pv_q       <= '0;
      pid_q      <= '0;
    end else begin
      state_q    <= state_d;
      pri_q      <= pri_d;
      sel_q      <= sel_d;
      lock_cnt_q <= lock_cnt_d;
      pv_q       <= pv_d;
      pid_q      <= pid_d;
    end
  end

  assign ack0_o     = gnt_v & ~gnt_id;
  assign ack1_o     = gnt_v & gnt_id;
  assign ram_en_o   = gnt_v;
  assign ram_we_o   = gnt_v & we_g;
  assign sel_o      = rst_i ? 1'b0 : (gnt_v ? gnt_id : sel_q);
  assign ram_addr_o = sel_o ? addr1_i : addr0_i;
  assign ram_wd_o   = sel_o ? wd1_i : wd0_i;

  // Last pipe stage lines up with RAM read data
  assign rvalid0_o = ~rst_i & pv_q[RD_LAT-1] & ~pid_q[RD_LAT-1];
  assign rvalid1_o = ~rst_i & pv_q[RD_LAT-1] & pid_q[RD_LAT-1];
  assign rd0_o     = ram_rd_i;
  assign rd1_o     = ram_rd_i;

endmodule

// File: tb/tb_common_ram_arb2.sv
// Self-checking bench for common_ram_arb2: vector table plus read-return scoreboard
// against a behavioural RAM with two-cycle read latency.
module tb_common_ram_arb2;

  localparam int unsigned AW       = 10;
  localparam int unsigned DW       = 40;
  localparam int unsigned RD_LAT   = 2;
  localparam int unsigned MAX_LOCK = 8;

  logic          clk;
  logic          rst;
  logic          req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wd0, wd1;
  logic          ack0, ack1, rvalid0, rvalid1;
  logic [DW-1:0] rd0, rd1;
  logic          sel, ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wd;
  logic [DW-1:0] ram_rd;

  common_ram_arb2 #(
    .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_LOCK(MAX_LOCK)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
    .addr0_i(addr0), .addr1_i(addr1), .wd0_i(wd0), .wd1_i(wd1),
    .lock0_i(lock0), .lock1_i(lock1),
    .ack0_o(ack0), .ack1_o(ack1), .rvalid0_o(rvalid0), .rvalid1_o(rvalid1),
    .rd0_o(rd0), .rd1_o(rd1), .sel_o(sel), .ram_en_o(ram_en), .ram_we_o(ram_we),
    .ram_addr_o(ram_addr), .ram_wd_o(ram_wd), .ram_rd_i(ram_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] fill(int a);
    return {8'h5A, 32'(a * 7 + 3)};
  endfunction

  // Behavioural RAM: unwritten locations read as fill(addr)
  logic [DW-1:0] mem [1024];
  bit            wr  [1024];
  logic [DW-1:0] rpipe [RD_LAT];
  always @(posedge clk) begin
    if (ram_en && ram_we) begin
      mem[ram_addr] <= ram_wd;
      wr[ram_addr]  <= 1'b1;
    end
    rpipe[0] <= wr[ram_addr] ? mem[ram_addr] : fill(int'(ram_addr));
    for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign ram_rd = rpipe[RD_LAT-1];

  typedef struct {
    bit rst, r0, r1, w0, w1, l0, l1;
    int a0, a1;
    bit e0, e1, esel;
  } vec_t;

  typedef struct {
    int            due;
    bit            id;
    logic [DW-1:0] data;
  } rd_t;

  vec_t          vecs[$];
  rd_t           sb[$];
  logic [DW-1:0] ref_mem [int];
  int            n_chk = 0;
  int            n_fail = 0;
  int            cyc = 0;

  function automatic vec_t mk(bit rs, bit r0, bit r1, bit w0, bit w1, bit l0, bit l1,
                              int a0, int a1, bit e0, bit e1, bit es);
    vec_t v;
    v.rst = rs; v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1; v.l0 = l0; v.l1 = l1;
    v.a0 = a0; v.a1 = a1; v.e0 = e0; v.e1 = e1; v.esel = es;
    return v;
  endfunction

  function automatic logic [DW-1:0] ref_read(int a);
    return ref_mem.exists(a) ? ref_mem[a] : fill(a);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle (entered at negedge), check outputs mid-cycle, update scoreboard
  task automatic apply(vec_t v);
    bit            erv0, erv1, g, gid;
    logic [DW-1:0] ed;
    int            ga;
    rst = v.rst; req0 = v.r0; req1 = v.r1; we0 = v.w0; we1 = v.w1;
    lock0 = v.l0; lock1 = v.l1; addr0 = AW'(v.a0); addr1 = AW'(v.a1);
    wd0 = {8'hC0, 32'(cyc)}; wd1 = {8'hD1, 32'(cyc)};
    #1;
    if (v.rst) sb.delete();
    erv0 = 1'b0; erv1 = 1'b0; ed = '0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      rd_t e;
      e = sb.pop_front();
      erv0 = ~e.id; erv1 = e.id; ed = e.data;
    end
    chk("rvalid0", 64'(rvalid0), 64'(erv0));
    chk("rvalid1", 64'(rvalid1), 64'(erv1));
    if (erv0) chk("rd0", 64'(rd0), 64'(ed));
    if (erv1) chk("rd1", 64'(rd1), 64'(ed));
    chk("ack0", 64'(ack0), 64'(v.e0));
    chk("ack1", 64'(ack1), 64'(v.e1));
    chk("sel", 64'(sel), 64'(v.esel));
    g   = v.e0 | v.e1;
    gid = v.e1;
    chk("ram_en", 64'(ram_en), 64'(g));
    if (g) begin
      ga = gid ? v.a1 : v.a0;
      chk("ram_we", 64'(ram_we), 64'(gid ? v.w1 : v.w0));
      chk("ram_addr", 64'(ram_addr), 64'(AW'(ga)));
      if (gid ? v.w1 : v.w0) begin
        ref_mem[ga] = gid ? wd1 : wd0;
      end else begin
        rd_t n;
        n.due = cyc + RD_LAT; n.id = gid; n.data = ref_read(ga);
        sb.push_back(n);
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    rst = 1'b1; req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = '0; addr1 = '0; wd0 = '0; wd1 = '0;

    // Reset with both requesting: no grants, SEL low
    vecs.push_back(mk(1,1,1,0,0,0,0, 0, 0, 0,0,0));
    vecs.push_back(mk(1,1,1,0,0,0,0, 0, 0, 0,0,0));
    // Round robin reads, fully pipelined alternating ports
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(0,1,1,0,0,0,0, i+1, i+11, (i%2)==0, (i%2)==1, (i%2)==1));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0, 0, 0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0, 0, 0,0,1));
    // Read p0 @5 then p1 @9
    vecs.push_back(mk(0,1,0,0,0,0,0, 5, 0, 1,0,0));
    vecs.push_back(mk(0,0,1,0,0,0,0, 0, 9, 0,1,1));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0, 0, 0,0,1));
    // Write then read-back across ports; write produces no rvalid
    vecs.push_back(mk(0,1,0,1,0,0,0, 5, 0, 1,0,0));
    vecs.push_back(mk(0,0,1,0,0,0,0, 0, 5, 0,1,1));
    vecs.push_back(mk(0,0,1,0,1,0,0, 0, 9, 0,1,1));
    // Lock cap: port 0 locked, port 1 joins on the 4th cycle
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0,1,0,0,0,1,0, 3, 0, 1,0,0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0,1,1,0,0,1,0, 3, 12, 1,0,0));
    vecs.push_back(mk(0,1,1,0,0,1,0, 3, 12, 0,1,1));
    vecs.push_back(mk(0,1,1,0,0,1,0, 3, 12, 1,0,0));
    // Owner drops REQ: other side takes it and locks
    vecs.push_back(mk(0,0,1,0,0,0,1, 0, 13, 0,1,1));
    vecs.push_back(mk(0,1,1,0,0,0,1, 4, 14, 0,1,1));
    vecs.push_back(mk(0,1,0,0,0,0,0, 4, 0, 1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0, 0, 0,0,0));
    // Reset with a read in flight
    vecs.push_back(mk(0,0,1,0,0,0,0, 0, 7, 0,1,1));
    vecs.push_back(mk(1,1,1,0,0,0,0, 0, 0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0, 0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0, 0, 0,0,0));
    vecs.push_back(mk(0,1,1,0,0,0,0, 6, 8, 1,0,0));

    @(negedge clk);
    foreach (vecs[i]) apply(vecs[i]);

    // Both ports locked and writing: ownership alternates every MAX_LOCK accesses
    for (int i = 0; i < 2 * MAX_LOCK + 1; i++) begin
      bit p;
      p = (i < int'(MAX_LOCK)) ? 1'b1 : ((i < 2 * int'(MAX_LOCK)) ? 1'b0 : 1'b1);
      apply(mk(0,1,1,1,1,1,1, 20, 21, ~p, p, p));
    end
    // Read back locked writes, then drain
    apply(mk(0,1,0,0,0,0,0, 20, 0, 1,0,0));
    apply(mk(0,0,1,0,0,0,0, 0, 21, 0,1,1));
    for (int i = 0; i < 4; i++) apply(mk(0,0,0,0,0,0,0, 0, 0, 0,0,1));
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
